// File: rtl/pipe_pkg.sv
// Shared types and width constants for the pipeline stage register.
// Included by pipe_stage_reg and its storage slot.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    localparam int unsigned PERF_CNT_W   = 32;

    localparam int unsigned EXMEM_CTRL_W = 8;
    localparam int unsigned EXMEM_DATA_W = 101;
    localparam int unsigned MEMWB_CTRL_W = 8;
    localparam int unsigned MEMWB_DATA_W = 69;

endpackage

// File: rtl/pipe_slot.sv
// One control+data storage entry of the stage register.
// clr_ctrl wins over load so a flushed beat never shows its control bits.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = EXMEM_CTRL_W,
    parameter int unsigned DATA_W = EXMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clr_ctrl,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        ctrl_d = ctrl_q;
        data_d = data_q;
        if (load) begin
            ctrl_d = in_ctrl;
            data_d = in_data;
        end
        if (clr_ctrl) begin
            ctrl_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q <= '0;
            data_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

    assign ctrl = ctrl_q;
    assign data = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer.
// Optional stall counter: define PIPE_PERF_CNT_EN to add the stall_cnt port.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = EXMEM_CTRL_W,
    parameter int unsigned DATA_W = EXMEM_DATA_W,
    parameter bit          SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cnt
`endif
);

    state_e state_q, state_d;

    logic in_fire, out_fire;
    logic main_load, main_clr, skid_load;
    logic [CTRL_W-1:0] main_src_ctrl, main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_src_data, main_data, skid_data;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (in_fire) state_d = ONE;
            ONE: begin
                if (SKID && in_fire && !out_fire) begin
                    state_d = TWO;
                end else if (!in_fire && out_fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: if (out_fire) state_d = ONE;
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_comb begin
        out_valid = (state_q != EMPTY);
        if (SKID) begin
            in_ready = (state_q != TWO);
        end else begin
            in_ready = !out_valid | out_ready;
        end
    end

    // Main refills from skid when draining TWO, otherwise from upstream.
    always_comb begin
        main_load = 1'b0;
        unique case (state_q)
            EMPTY:   main_load = in_fire;
            ONE:     main_load = in_fire & out_fire;
            TWO:     main_load = out_fire;
            default: main_load = 1'b0;
        endcase
        main_load = main_load & !flush;
        main_clr  = flush | (state_d == EMPTY);
        skid_load = SKID && (state_q == ONE) && in_fire
                    && !out_fire && !flush;
        main_src_ctrl = (state_q == TWO) ? skid_ctrl : in_ctrl;
        main_src_data = (state_q == TWO) ? skid_data : in_data;
    end

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk      (clk),
        .rst      (rst),
        .load     (main_load),
        .clr_ctrl (main_clr),
        .in_ctrl  (main_src_ctrl),
        .in_data  (main_src_data),
        .ctrl     (main_ctrl),
        .data     (main_data)
    );

    if (SKID) begin : g_skid
        pipe_slot #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W)
        ) u_skid (
            .clk      (clk),
            .rst      (rst),
            .load     (skid_load),
            .clr_ctrl (flush),
            .in_ctrl  (in_ctrl),
            .in_data  (in_data),
            .ctrl     (skid_ctrl),
            .data     (skid_data)
        );
    end else begin : g_no_skid
        assign skid_ctrl = '0;
        assign skid_data = '0;
    end

    assign out_ctrl = main_ctrl;
    assign out_data = main_data;

`ifdef PIPE_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && !out_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized bench for pipe_stage_reg against a FIFO-queue reference model.
// Covers reset, streaming, back-pressure, flush, async reset, perf counter.
module tb_pipe_stage_reg;

    localparam int CW = 8;
    localparam int DW = 101;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    beat_t         q[$];
    logic [DW-1:0] m_last = '0;
    logic [31:0]   m_cnt = '0;

    pipe_stage_reg #(
        .CTRL_W (CW),
        .DATA_W (DW),
        .SKID   (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_ready();
        return q.size() < 2;
    endfunction

    task automatic model_reset();
        q.delete();
        m_last = '0;
        m_cnt  = '0;
    endtask

    task automatic check_outputs();
        chk("out_valid", out_valid, q.size() > 0);
        chk("out_ctrl", out_ctrl, q.size() > 0 ? q[0].c : '0);
        chk("out_data", out_data, q.size() > 0 ? q[0].d : m_last);
        chk("in_ready", in_ready, m_ready());
`ifdef PIPE_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, m_cnt);
`endif
    endtask

    // Entered and left at posedge+1.
    task automatic cycle(input logic iv, input logic [CW-1:0] ic,
                         input logic [DW-1:0] id, input logic ordy,
                         input logic fl);
        logic ifire, ofire;
        beat_t b;
        in_valid  = iv;
        in_ctrl   = ic;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #4;
        check_outputs();
        ifire = iv & m_ready();
        ofire = (q.size() > 0) & ordy;
        if (q.size() > 0 && !ordy && m_cnt != 32'hFFFF_FFFF) m_cnt++;
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
        end else begin
            if (ofire) void'(q.pop_front());
            if (ifire) begin
                b.c = ic;
                b.d = id;
                q.push_back(b);
            end
        end
        if (q.size() > 0) m_last = q[0].d;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    initial begin
        int guard;
        logic [CW-1:0] c3;

        rst = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_ctrl  = 8'hA5;
        in_data  = 101'h1234;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_ctrl", out_ctrl, '0);
        chk("rst_data", out_data, '0);
        chk("rst_ready", in_ready, 1'b1);
        rst = 1'b1;
        model_reset();

        cycle(1'b1, 8'hA5, 101'h1234, 1'b1, 1'b0);
        chk("basic_ctrl", out_ctrl, 8'hA5);
        chk("basic_data", out_data, 101'h1234);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, CW'(i), DW'(i), 1'b1, 1'b0);
        end
        cycle(1'b0, '0, '0, 1'b1, 1'b0);

        cycle(1'b1, 8'h01, 101'h1, 1'b0, 1'b0);
        cycle(1'b1, 8'h02, 101'h2, 1'b0, 1'b0);
        chk("bp_ready_low", in_ready, 1'b0);
        cycle(1'b1, 8'h03, 101'h3, 1'b0, 1'b0);
        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            c3 = (q[q.size()-1].c == 8'h03) ? 8'h00 : 8'h03;
            cycle(c3 != 0, c3, DW'(c3), 1'b1, 1'b0);
            guard++;
        end
        chk("bp_drain", q.size() == 0, 1'b1);

        cycle(1'b1, 8'h11, 101'h11, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 101'h22, 1'b0, 1'b0);
        chk("fl_two", in_ready, 1'b0);
        cycle(1'b1, 8'hFF, 101'hFF, 1'b0, 1'b1);
        chk("fl_valid", out_valid, 1'b0);
        chk("fl_ctrl", out_ctrl, '0);
        chk("fl_ready", in_ready, 1'b1);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);

        cycle(1'b1, 8'h5A, 101'h77, 1'b0, 1'b0);
        chk("ar_one", out_valid, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        chk("ar_valid", out_valid, 1'b0);
        chk("ar_ctrl", out_ctrl, '0);
        chk("ar_data", out_data, '0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;

`ifdef PIPE_PERF_CNT_EN
        cycle(1'b1, 8'h33, 101'h33, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b0);
        end
        chk("perf5", stall_cnt, 32'd5);
        cycle(1'b0, '0, '0, 1'b1, 1'b1);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        chk("perf_flush", stall_cnt, 32'd5);
`endif

        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, CW'($urandom), rnd_data(),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end
        cycle(1'b0, '0, '0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register, successor to the fixed-field EX/MEM latch of the five-stage core. It carries an opaque control vector and data vector between two pipeline stages using a valid/ready handshake, with an optional 2-entry skid buffer so back-pressure does not form a combinational path. It also provides a synchronous flush that inserts a zero-control bubble. All MEM/WB and EX/MEM boundaries of the core will be built from this block.

## Interface
- CTRL_W, 8: width of control vector; zeroed on reset, flush and bubble.
- DATA_W, 101: width of datapath vector (alu_out, RD2, b_tgt, rfile_wn packed by the instantiating stage).
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset. It is asynchronous and active-low: rst = 0 resets immediately, independent of clk.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream has a beat.
- in_ready  out  1  block can accept a beat.
- in_ctrl  in  CTRL_W  upstream control bits.
- in_data  in  DATA_W  upstream data bits.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts the output beat.
- out_ctrl  out  CTRL_W  control bits; all 0 whenever out_valid = 0.
- out_data  out  DATA_W  data bits; hold their last value when out_valid = 0.
- stall_cnt  out  32  present only with PIPE_PERF_CNT_EN.

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset values:
  - out_valid = 0, out_ctrl = 0, out_data = 0.
  - in_ready = 1.
  - stall_cnt = 0.
  - State = EMPTY.
- Storage is a main slot, which drives the outputs, plus, with SKID = 1, a skid slot.
- State machine with SKID = 1:
  - EMPTY:
    - in_fire → ONE, main ← in.
  - ONE:
    - in_fire & out_fire → ONE, main ← in.
    - in_fire & !out_fire → TWO, skid ← in.
    - !in_fire & out_fire → EMPTY.
    - Otherwise hold.
  - TWO:
    - out_fire → ONE, main ← skid.
    - Otherwise hold. in_ready = 0, so no in_fire can occur.
- With SKID = 1, in_ready = (state != TWO), decoded from a state register with no combinational input dependency.
- With SKID = 0, the states are EMPTY and ONE only, and in_ready = !out_valid | out_ready (combinational).
- out_valid = (state != EMPTY).
- When entering EMPTY, the main-slot control bits clear to 0; data bits are not cleared.
- flush = 1 at an edge:
  - Next state is EMPTY from any state.
  - Main and skid control bits clear to 0.
  - flush overrides in_fire and out_fire in the same cycle. A beat accepted in that cycle is discarded, and the upstream is flushed in the same cycle by contract.
- Ordering is strict FIFO. No beat is duplicated or dropped except by flush.
- When rst is asserted mid-operation, all entries are lost and the outputs take their reset values immediately.

## Timing
- Latency: in_fire at edge N gives out_valid = 1 after edge N, when starting from EMPTY or from ONE with out_fire.
- Throughput: 1 beat/cycle when out_ready is held at 1.
- SKID = 1: in_ready falls one cycle after the first stalled accept, and rises the cycle after out_fire in TWO.
- SKID = 0: in_ready depends combinationally on out_ready in the same cycle.
- flush takes effect at the next edge: out_valid = 0 and out_ctrl = 0 from then on.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - Adds the stall_cnt port and a 32-bit counter.
  - The counter increments each cycle out_valid & !out_ready.
  - It saturates at 32'hFFFF_FFFF.
  - It is cleared only by rst; flush does not clear it.
- PIPE_PERF_CNT_EN undefined: no counter logic and no stall_cnt port.

## Structure
- Package pipe_pkg contains:
  - State enum: EMPTY, ONE, TWO.
  - PERF_CNT_W = 32.
  - Default CTRL_W and DATA_W constants for the EX/MEM and MEM/WB boundaries.
- Sub-module pipe_slot: one CTRL_W + DATA_W storage entry with load and clear-ctrl inputs, async active-low reset. Instantiated once for main and, with SKID = 1, once for skid.

## Test plan
- Reset and basic transfer:
  - Stimulus: rst low, then high; in_valid = 1, in_ctrl = 8'hA5, in_data = 101'h1234; out_ready = 1.
  - Required: out_valid = 1 with ctrl A5 and data 1234 one cycle later; outputs were all 0 during reset.
- Streaming:
  - Stimulus: 16 consecutive beats with values 0..15, out_ready held at 1.
  - Required: 16 outputs in order, one per cycle, in_ready constantly 1.
- Back-pressure (SKID = 1):
  - Stimulus: out_ready = 0 while beats 1 and 2 are sent.
  - Required: state TWO, in_ready = 0 on the next cycle, beat 3 held upstream. After out_ready = 1, beats arrive in the order 1, 2, 3 with no loss.
- Flush:
  - Stimulus: in state TWO, flush = 1 together with in_valid = 1 (ctrl 8'hFF).
  - Required: the next cycle shows out_valid = 0, out_ctrl = 0, in_ready = 1, and beat FF never appears.
- Async reset mid-stream:
  - Stimulus: drop rst between clock edges while in ONE.
  - Required: out_valid = 0 immediately, without waiting for clk.
- Perf counter (PIPE_PERF_CNT_EN):
  - Stimulus: 5 cycles of out_valid = 1, out_ready = 0, then a flush.
  - Required: stall_cnt = 5, and it stays 5 after the flush.
